// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the parametrised system bus arbiter.
package sys_bus_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } bus_state_e;

    // Default slave map, indexed by the top address bits.
    localparam int unsigned SLV_RAM   = 0;
    localparam int unsigned SLV_TIMER = 1;
    localparam int unsigned SLV_UART  = 2;
    localparam int unsigned SLV_GPIO  = 3;

    // Index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational circular priority search: first requester at or after ptr_i wins.
module rr_arbiter #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdxW   = 1
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    int unsigned cand;

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand = (32'(ptr_i) + k) % NumReq;
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/sys_bus_arb.sv
// Round-robin multi-master system bus with burst limit and top-bit slave decode.
// Define SYS_BUS_DECERR_EN to add m_err / err_adr decode-error reporting.
module sys_bus_arb
    import sys_bus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned NUM_SLAVES  = 4,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned MAX_BURST   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MASTERS-1:0]    m_request,
    input  logic [NUM_MASTERS-1:0]    m_we,
    input  logic [NUM_MASTERS*AW-1:0] m_adr,
    input  logic [NUM_MASTERS*DW-1:0] m_wdata,
    output logic [NUM_MASTERS*DW-1:0] m_rdata,
    output logic [NUM_MASTERS-1:0]    m_hold,
    output logic [NUM_SLAVES-1:0]     s_sel,
    output logic [NUM_SLAVES-1:0]     s_we,
    output logic [AW-1:0]             s_adr,
    output logic [DW-1:0]             s_wdata,
`ifdef SYS_BUS_DECERR_EN
    output logic [NUM_MASTERS-1:0]    m_err,
    output logic [AW-1:0]             err_adr,
`endif
    input  logic [NUM_SLAVES*DW-1:0]  s_rdata
);

    localparam int unsigned MIDX_W = clog2_min1(NUM_MASTERS);
    localparam int unsigned SEL_W  = clog2_min1(NUM_SLAVES);

    bus_state_e        state_q, state_d;
    logic [MIDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [MIDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]        burst_cnt_q, burst_cnt_d;

    logic [MIDX_W-1:0]      arb_idx;
    logic                   arb_valid;
    logic                   granted;
    logic [NUM_MASTERS-1:0] gnt_onehot;
    logic [AW-1:0]          gnt_adr;
    logic [SEL_W-1:0]       slave_idx;
    logic                   mapped;
    logic [MIDX_W-1:0]      next_ptr;
    logic                   burst_limit;

    rr_arbiter #(
        .NumReq (NUM_MASTERS),
        .IdxW   (MIDX_W)
    ) u_rr_arbiter (
        .req_i   (m_request),
        .ptr_i   (rr_ptr_q),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign granted     = (state_q == StGrant);
    assign gnt_adr     = m_adr[gnt_idx_q*AW +: AW];
    assign slave_idx   = gnt_adr[AW-1 -: SEL_W];
    assign mapped      = 32'(slave_idx) < NUM_SLAVES;
    assign next_ptr    = (32'(gnt_idx_q) == NUM_MASTERS - 1) ? '0 : gnt_idx_q + 1'b1;
    assign burst_limit = burst_cnt_q >= 8'(MAX_BURST - 1);

    always_comb begin
        gnt_onehot            = '0;
        gnt_onehot[gnt_idx_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            gnt_idx_q   <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_idx_q   <= gnt_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_idx_d   = gnt_idx_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    state_d     = StGrant;
                    gnt_idx_d   = arb_idx;
                    burst_cnt_d = '0;
                end
            end
            StGrant: begin
                if (burst_cnt_q != 8'hFF) burst_cnt_d = burst_cnt_q + 8'd1;
                // >= rather than == so a late-arriving requester is never starved
                if (!m_request[gnt_idx_q] ||
                    (burst_limit && |(m_request & ~gnt_onehot))) begin
                    state_d  = StIdle;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        s_sel   = '0;
        s_we    = '0;
        s_adr   = '0;
        s_wdata = '0;
        m_rdata = '0;
        if (granted) begin
            s_adr                  = gnt_adr;
            s_adr[AW-1 -: SEL_W]   = '0;
            s_wdata                = m_wdata[gnt_idx_q*DW +: DW];
            if (mapped) begin
                s_sel[slave_idx]               = 1'b1;
                s_we[slave_idx]                = m_we[gnt_idx_q];
                m_rdata[gnt_idx_q*DW +: DW]    = s_rdata[slave_idx*DW +: DW];
            end
        end
    end

    // Gated by rst so holds drop immediately while reset is asserted.
    assign m_hold = rst ? '0 : (m_request & ~(granted ? gnt_onehot : '0));

`ifdef SYS_BUS_DECERR_EN
    logic [AW-1:0] last_err_adr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_err_adr_q <= '0;
        end else if (granted && !mapped) begin
            last_err_adr_q <= gnt_adr;
        end
    end

    always_comb begin
        m_err = '0;
        if (granted && !mapped) m_err[gnt_idx_q] = 1'b1;
    end

    assign err_adr = last_err_adr_q;
`endif

endmodule

// File: doc/sys_bus_arb.md
Name: sys_bus_arb

Overview:
- Parametrised successor to the fixed two-master/two-slave system bus.
- Connects NUM_MASTERS bus masters (CPU, future DMA) to NUM_SLAVES memory-mapped slaves (timer, RAM, UART, ...).
- Arbitration is registered round-robin with a grant lock and a burst limit. Slaves are selected by decoding the top address bits.
- Every master that is requesting but not granted receives a per-master hold, which replaces the single, unused hold_flag.

Parameters:
- NUM_MASTERS, 2, number of masters (1..8).
- NUM_SLAVES, 4, number of slaves (1..16).
- AW, 32, address width.
- DW, 32, data width.
- MAX_BURST, 8, maximum consecutive granted cycles while another master is waiting (1..255).
- Derived localparams: MIDX_W = max(1, clog2(NUM_MASTERS)); SEL_W = max(1, clog2(NUM_SLAVES)).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- m_request  in  NUM_MASTERS  per-master bus request
- m_we  in  NUM_MASTERS  per-master write enable
- m_adr  in  NUM_MASTERS*AW  packed addresses; master i occupies [i*AW +: AW]
- m_wdata  in  NUM_MASTERS*DW  packed write data
- m_rdata  out  NUM_MASTERS*DW  packed read data
- m_hold  out  NUM_MASTERS  stall flag for each master
- s_sel  out  NUM_SLAVES  one-hot slave select
- s_we  out  NUM_SLAVES  per-slave write strobe
- s_adr  out  AW  shared address: the granted master's address with the top SEL_W bits zeroed
- s_wdata  out  DW  shared write data
- s_rdata  in  NUM_SLAVES*DW  packed slave read data

Behaviour:
- FSM states: IDLE, GRANT. Registers: gnt_idx (MIDX_W bits), rr_ptr (MIDX_W bits), burst_cnt (8 bits).
- Reset (asynchronous, any time, including mid-grant):
  - state=IDLE, gnt_idx=0, rr_ptr=0, burst_cnt=0.
  - All outputs 0, including m_hold.
- IDLE:
  - If any m_request is high, pick the first requester at or after rr_ptr, searching circularly.
  - Load gnt_idx with that master, go to GRANT next edge, clear burst_cnt.
  - The bus presents nothing in IDLE. Latency from request to first slave access is 1 cycle.
- GRANT:
  - Combinationally forward the granted master to the slave side: s_adr/s_wdata from m_adr/m_wdata[gnt_idx].
  - slave_idx = m_adr[gnt_idx][AW-1 -: SEL_W].
  - If slave_idx < NUM_SLAVES: s_sel[slave_idx]=1, and s_we[slave_idx] = m_we[gnt_idx].
  - m_rdata[gnt_idx] = s_rdata[slave_idx], same cycle.
  - Unmapped index (slave_idx >= NUM_SLAVES): no s_sel or s_we asserted; m_rdata[gnt_idx] = 0.
  - burst_cnt increments each GRANT cycle, saturating at 255.
- Leaving GRANT:
  - Granted master drops its request: return to IDLE, rr_ptr = gnt_idx+1 mod NUM_MASTERS.
  - burst_cnt == MAX_BURST-1 and any other master is requesting: forced release to IDLE, rr_ptr = gnt_idx+1. The granted master then sees m_hold=1 until it is re-granted.
  - burst_cnt reaches the limit with no other requester: stay in GRANT and keep burst_cnt saturated.
- m_hold[i] = m_request[i] & ~(state==GRANT & gnt_idx==i). A hold is therefore asserted in the IDLE arbitration cycle as well.
- m_rdata for non-granted masters is 0.
- Simultaneous requests in IDLE are resolved purely by rr_ptr. Master 0 has no fixed priority.
- NUM_MASTERS=1: the burst limit never forces a release.

Optional Feature:
- Macro SYS_BUS_DECERR_EN.
- When defined:
  - Adds output port m_err (NUM_MASTERS). m_err[gnt_idx] = 1 in any GRANT cycle that accesses an unmapped slave index.
  - Adds a sticky register last_err_adr (AW bits), exposed as output err_adr, which captures the faulting address. Reset value 0.
- When undefined: neither port exists, and unmapped accesses are silently read as 0 with writes dropped.

Decomposition:
- Package sys_bus_pkg holds:
  - the SEL_W/MIDX_W clog2 helper function;
  - the FSM state encoding (IDLE=1'b0, GRANT=1'b1);
  - the default slave map constants (SLV_RAM=0, SLV_TIMER=1, SLV_UART=2, SLV_GPIO=3).
- One natural sub-module, rr_arbiter: a combinational circular priority search. Inputs are request vector and rr_ptr; outputs are the winner index and a valid flag.

Test Plan:
- Reset: assert rst mid-GRANT with master 1 writing slave 2 -> same cycle, all s_we/s_sel/m_hold = 0; after release, state is IDLE with rr_ptr=0.
- Single master 0 writes 0xDEADBEEF to 0x1000_0004 (NUM_SLAVES=4, SEL_W=2) -> one cycle later s_sel=4'b0001 (slave 0), s_we[0]=1, s_adr=0x1000_0004; m_hold[0]=1 only in the first cycle.
- Master 0 reads 0x4000_0010 -> s_sel[1]=1; slave 1 drives 0x12345678 -> m_rdata[0]=0x12345678 in the same cycle.
- Both masters request continuously, MAX_BURST=4 -> grant sequence is master 0 for 4 cycles, 1 IDLE cycle, master 1 for 4 cycles, repeating; the waiting master's m_hold stays 1 throughout.
- Simultaneous requests after master 1's grant ends -> master 0 wins (rr_ptr=0); on the next contention master 1 wins.
- NUM_SLAVES=3, access to 0xC000_0000 -> no s_sel, m_rdata=0; with SYS_BUS_DECERR_EN, m_err[0]=1 and err_adr=0xC000_0000.
